board_mem_arbiter: RTL and testbench

BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

---
 rtl/board_mem_arbiter_if.sv | 71 +++++++
 rtl/board_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_board_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// board_mem_arbiter_if
//
// Bundles every non-clock/non-reset signal of the board memory arbiter.
//   slave  modport : the arbiter's view (requests in, grants/data out)
//   master modport : the board's view (renderer, updater, video timing, memory)
//
// Signal groups:
//   renderer : render_en_in, render_addr_in, render_data_out
//   updater  : upd_req_in, upd_addr_in, upd_gnt_out, upd_data_out, upd_valid_out
//   swap     : swap_req_in, vblank_in, swap_ack_out, front_bank_out
//   memory   : mem_en_out, mem_addr_out ({bank, word addr}), mem_data_in
//   debug    : swap_pending_dbg (1 while a bank swap is waiting)
//
// Handshakes:
//   Renderer reads are fire-and-forget: render_en_in is never back-pressured
//   and the word appears on render_data_out a fixed latency later. The updater
//   uses request/grant: upd_req_in and upd_addr_in stay stable until
//   upd_gnt_out=1 in the same cycle; the transfer happens on that rising edge
//   and the data returns as a single-cycle upd_valid_out pulse. swap_req_in is
//   a request that is acknowledged by a one-cycle swap_ack_out pulse.
// ---------------------------------------------------------------------------
interface board_mem_arbiter_if #(
    parameter int LOG_MAX_ADDR = 16,
    parameter int WORD_SIZE    = 32
);
    logic                    render_en_in;
    logic [LOG_MAX_ADDR-1:0] render_addr_in;
    logic [WORD_SIZE-1:0]    render_data_out;

    logic                    upd_req_in;
    logic [LOG_MAX_ADDR-1:0] upd_addr_in;
    logic                    upd_gnt_out;
    logic [WORD_SIZE-1:0]    upd_data_out;
    logic                    upd_valid_out;

    logic                    swap_req_in;
    logic                    vblank_in;
    logic                    swap_ack_out;
    logic                    front_bank_out;

    logic                    mem_en_out;
    logic [LOG_MAX_ADDR:0]   mem_addr_out;
    logic [WORD_SIZE-1:0]    mem_data_in;

    logic                    swap_pending_dbg;

    modport slave (
        input  render_en_in, render_addr_in,
        output render_data_out,
        input  upd_req_in, upd_addr_in,
        output upd_gnt_out, upd_data_out, upd_valid_out,
        input  swap_req_in, vblank_in,
        output swap_ack_out, front_bank_out,
        output mem_en_out, mem_addr_out,
        input  mem_data_in,
        output swap_pending_dbg
    );

    modport master (
        output render_en_in, render_addr_in,
        input  render_data_out,
        output upd_req_in, upd_addr_in,
        input  upd_gnt_out, upd_data_out, upd_valid_out,
        output swap_req_in, vblank_in,
        input  swap_ack_out, front_bank_out,
        input  mem_en_out, mem_addr_out,
        output mem_data_in,
        input  swap_pending_dbg
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// ---------------------------------------------------------------------------
// board_mem_arbiter
//
// Shares one double-buffered board memory between a renderer (reads the front
// bank every cycle it asks, never stalled) and an updater (reads the back bank
// when the renderer is idle). Also owns the front/back bank selection and
// swaps the banks during vertical blank on the updater's request.
//
// Ports:
//   clk_in    : single clock, all state on the rising edge
//   rst_n_in  : asynchronous active-low reset
//   bus       : board_mem_arbiter_if.slave (renderer, updater, swap, memory)
//
// Parameters:
//   LOG_MAX_ADDR : word-address width per bank (board default 16)
//   WORD_SIZE    : memory word width (board default 32)
//   READ_LATENCY : cycles from mem_en_out/mem_addr_out sampled by the memory
//                  to mem_data_in valid; legal range 1..4
//
// Timing: a request sampled at edge N drives mem_en_out/mem_addr_out after
// edge N, the memory samples them at N+1, and the word is captured at edge
// N+1+READ_LATENCY. A (1+READ_LATENCY)-deep shift register carries the owner
// of every issued read so returns are steered in issue order.
// ---------------------------------------------------------------------------
module board_mem_arbiter #(
    parameter int LOG_MAX_ADDR = 16,
    parameter int WORD_SIZE    = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    board_mem_arbiter_if.slave  bus
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } swap_state_t;

    swap_state_t state_q, state_d;

    // defer_q: a vblank rise was seen while a swap was wanted but an updater
    // read was still in flight; the swap may then happen on any later cycle
    // of the same vblank once the pipeline drains.
    logic defer_q, defer_d;
    logic swap_fire;
    logic vblank_q;
    logic vblank_rise;
    logic front_q;
    logic swap_ack_q;

    logic [READ_LATENCY:0]   pipe_ren_q;
    logic [READ_LATENCY:0]   pipe_upd_q;
    logic                    upd_inflight;
    logic                    upd_gnt;

    logic                    mem_en_q;
    logic [LOG_MAX_ADDR:0]   mem_addr_q;
    logic [WORD_SIZE-1:0]    render_data_q;
    logic [WORD_SIZE-1:0]    upd_data_q;
    logic                    upd_valid_q;

    // ------------------------------------------------------------------
    // Arbitration: renderer always wins; the updater is also held off
    // while a swap is waiting so the back bank drains before it flips.
    // ------------------------------------------------------------------
    assign vblank_rise  = bus.vblank_in & ~vblank_q;
    assign upd_inflight = |pipe_upd_q;
    assign upd_gnt      = bus.upd_req_in & ~bus.render_en_in
                        & (state_q != S_PENDING) & rst_n_in;

    // ------------------------------------------------------------------
    // Swap FSM, next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        defer_d   = defer_q;
        swap_fire = 1'b0;

        // A deferred swap only stays armed for the vblank that armed it.
        if (!bus.vblank_in) begin
            defer_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.swap_req_in) begin
                    if (vblank_rise && !upd_inflight) begin
                        // Request lands on the rise itself: swap right away.
                        swap_fire = 1'b1;
                    end else begin
                        state_d = S_PENDING;
                        if (vblank_rise) begin
                            defer_d = 1'b1;
                        end
                    end
                end
            end
            S_PENDING: begin
                if (bus.vblank_in && (vblank_rise || defer_q)) begin
                    if (!upd_inflight) begin
                        swap_fire = 1'b1;
                        state_d   = S_IDLE;
                        defer_d   = 1'b0;
                    end else begin
                        defer_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                defer_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Swap FSM, state and bank registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            defer_q    <= 1'b0;
            vblank_q   <= 1'b0;
            front_q    <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            defer_q    <= defer_d;
            vblank_q   <= bus.vblank_in;
            swap_ack_q <= swap_fire;
            if (swap_fire) begin
                front_q <= ~front_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory issue, owner pipeline and return capture.
    // The bank bit is taken from front_q before any toggle on the same
    // edge, so a read is bound to the bank that was current at issue.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            pipe_ren_q    <= '0;
            pipe_upd_q    <= '0;
            render_data_q <= '0;
            upd_data_q    <= '0;
            upd_valid_q   <= 1'b0;
        end else begin
            mem_en_q <= bus.render_en_in | upd_gnt;
            if (bus.render_en_in) begin
                mem_addr_q <= {front_q, bus.render_addr_in};
            end else if (upd_gnt) begin
                mem_addr_q <= {~front_q, bus.upd_addr_in};
            end

            pipe_ren_q <= {pipe_ren_q[READ_LATENCY-1:0], bus.render_en_in};
            pipe_upd_q <= {pipe_upd_q[READ_LATENCY-1:0], upd_gnt};

            if (pipe_ren_q[READ_LATENCY]) begin
                render_data_q <= bus.mem_data_in;
            end

            upd_valid_q <= pipe_upd_q[READ_LATENCY];
            if (pipe_upd_q[READ_LATENCY]) begin
                upd_data_q <= bus.mem_data_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.upd_gnt_out      = upd_gnt;
    assign bus.upd_data_out     = upd_data_q;
    assign bus.upd_valid_out    = upd_valid_q;
    assign bus.render_data_out  = render_data_q;
    assign bus.mem_en_out       = mem_en_q;
    assign bus.mem_addr_out     = mem_addr_q;
    assign bus.front_bank_out   = front_q;
    assign bus.swap_ack_out     = swap_ack_q;
    assign bus.swap_pending_dbg = (state_q == S_PENDING);

endmodule

// File: tb/tb_board_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_board_mem_arbiter
//
// Drives the arbiter with directed and randomized traffic and compares every
// output, every cycle, against a transaction-level reference: a read issued on
// edge E is expected back on edge E+READ_LATENCY+1, kept in per-requester
// queues of due edge and expected word; the bank swap is modelled from the
// vblank/request rules directly.
// ---------------------------------------------------------------------------
module tb_board_mem_arbiter;

    localparam int LA = 8;
    localparam int WS = 16;
    localparam int RL = 2;

    logic clk_in;
    logic rst_n_in;

    board_mem_arbiter_if #(.LOG_MAX_ADDR(LA), .WORD_SIZE(WS)) bus ();

    board_mem_arbiter #(
        .LOG_MAX_ADDR (LA),
        .WORD_SIZE    (WS),
        .READ_LATENCY (RL)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- memory model ----------------
    // Word contents are a fixed function of {bank, addr}; word {0,0x05} is 0xA5A5.
    function automatic logic [WS-1:0] mem_word(input logic [LA:0] a);
        return 16'hA5A0 ^ {a[LA], 6'd0, a};
    endfunction

    logic [LA:0] mh [RL];
    always @(posedge clk_in) begin
        mh[0] <= bus.mem_addr_out;
        for (int k = 1; k < RL; k++) mh[k] <= mh[k-1];
    end
    assign bus.mem_data_in = mem_word(mh[RL-1]);

    // ---------------- scoreboard / reference ----------------
    int n_total;
    int n_bad;

    int            upd_due_q[$];
    logic [WS-1:0] upd_exp_q[$];
    int            ren_due_q[$];
    logic [WS-1:0] ren_exp_q[$];

    int            m_edge;
    logic          m_front, m_pending, m_window, m_vb_prev, m_ack;
    logic          m_mem_en;
    logic [LA:0]   m_mem_addr;
    logic [WS-1:0] m_render_data, m_upd_data;
    logic          m_upd_valid;
    logic          last_gnt;
    int            n_swaps;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        upd_due_q.delete(); upd_exp_q.delete();
        ren_due_q.delete(); ren_exp_q.delete();
        m_front = 0; m_pending = 0; m_window = 0; m_vb_prev = 0; m_ack = 0;
        m_mem_en = 0; m_mem_addr = '0;
        m_render_data = '0; m_upd_data = '0; m_upd_valid = 0;
    endtask

    task automatic check_outputs();
        check("render_data", bus.render_data_out, m_render_data);
        check("upd_valid",   bus.upd_valid_out,   m_upd_valid);
        check("upd_data",    bus.upd_data_out,    m_upd_data);
        check("mem_en",      bus.mem_en_out,      m_mem_en);
        check("mem_addr",    bus.mem_addr_out,    m_mem_addr);
        check("front_bank",  bus.front_bank_out,  m_front);
        check("swap_ack",    bus.swap_ack_out,    m_ack);
    endtask

    // Advance the reference across one rising edge with the inputs that edge sampled.
    task automatic model_edge(input logic r_en, input logic [LA-1:0] r_addr,
                              input logic gnt, input logic [LA-1:0] u_addr,
                              input logic s_req, input logic vb);
        logic outstanding;
        logic rise;
        outstanding = (upd_due_q.size() != 0);

        m_upd_valid = 0;
        if (upd_due_q.size() != 0 && upd_due_q[0] == m_edge) begin
            void'(upd_due_q.pop_front());
            m_upd_data  = upd_exp_q.pop_front();
            m_upd_valid = 1;
        end
        if (ren_due_q.size() != 0 && ren_due_q[0] == m_edge) begin
            void'(ren_due_q.pop_front());
            m_render_data = ren_exp_q.pop_front();
        end

        m_mem_en = r_en | gnt;
        if (r_en) begin
            m_mem_addr = {m_front, r_addr};
            ren_due_q.push_back(m_edge + RL + 1);
            ren_exp_q.push_back(mem_word(m_mem_addr));
        end else if (gnt) begin
            m_mem_addr = {~m_front, u_addr};
            upd_due_q.push_back(m_edge + RL + 1);
            upd_exp_q.push_back(mem_word(m_mem_addr));
        end

        rise  = vb & ~m_vb_prev;
        m_ack = 0;
        if (!vb) m_window = 0;
        if (m_pending || s_req) begin
            if (vb && (rise || m_window)) begin
                if (!outstanding) begin
                    m_front   = ~m_front;
                    m_ack     = 1;
                    m_pending = 0;
                    m_window  = 0;
                    n_swaps++;
                end else begin
                    m_pending = 1;
                    m_window  = 1;
                end
            end else begin
                m_pending = 1;
            end
        end
        m_vb_prev = vb;
        m_edge++;
    endtask

    // ---------------- driver ----------------
    // Entered and left at posedge+1.
    task automatic cycle(input logic r_en, input logic [LA-1:0] r_addr,
                         input logic u_req, input logic [LA-1:0] u_addr,
                         input logic s_req, input logic vb);
        logic gnt_exp;
        bus.render_en_in   = r_en;
        bus.render_addr_in = r_addr;
        bus.upd_req_in     = u_req;
        bus.upd_addr_in    = u_addr;
        bus.swap_req_in    = s_req;
        bus.vblank_in      = vb;
        #1;
        gnt_exp = u_req & ~r_en & ~m_pending;
        check("upd_gnt", bus.upd_gnt_out, gnt_exp);
        check("swap_pending_dbg", bus.swap_pending_dbg, m_pending);
        last_gnt = gnt_exp;
        @(posedge clk_in);
        #1;
        model_edge(r_en, r_addr, gnt_exp, u_addr, s_req, vb);
        check_outputs();
    endtask

    task automatic idle(input int n, input logic vb);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, vb);
    endtask

    // Asynchronous reset asserted between edges, checked before any edge.
    task automatic mid_cycle_reset();
        #3;
        bus.upd_req_in   = 1'b1;
        bus.render_en_in = 1'b0;
        rst_n_in = 1'b0;
        #1;
        model_reset();
        check("rst_gnt", bus.upd_gnt_out, 1'b0);
        check_outputs();
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        check_outputs();
        rst_n_in = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic          r_en, u_req, s_req, vb;
    logic [LA-1:0] r_addr, u_addr;
    int            grants_seen;
    int            swaps_before;

    initial begin
        n_total = 0; n_bad = 0; m_edge = 0; n_swaps = 0; last_gnt = 0;
        model_reset();
        rst_n_in = 1'b1;
        bus.render_en_in = 0; bus.render_addr_in = '0;
        bus.upd_req_in = 0; bus.upd_addr_in = '0;
        bus.swap_req_in = 0; bus.vblank_in = 0;
        #2 rst_n_in = 1'b0;
        #10;
        check_outputs();
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;

        // Render read of word 5 returns 0xA5A5 three edges later.
        cycle(1'b1, 8'h05, 1'b0, '0, 1'b0, 1'b0);
        check("render_addr_bank0", bus.mem_addr_out, 9'h005);
        idle(3, 1'b0);
        check("render_a5a5", bus.render_data_out, 16'hA5A5);

        // Renderer and updater contend for 3 cycles; updater wins the 4th.
        grants_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 8'h3C, 1'b0, 1'b0);
            grants_seen += int'(last_gnt);
        end
        check("no_gnt_under_render", grants_seen, 0);
        cycle(1'b0, '0, 1'b1, 8'h3C, 1'b0, 1'b0);
        check("gnt_4th", last_gnt, 1'b1);
        check("upd_bank1", bus.mem_addr_out, {1'b1, 8'h3C});
        idle(4, 1'b0);

        // Swap request outside vblank blocks grants until the vblank rise.
        swaps_before = n_swaps;
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'h11, 1'b0, 1'b1);
        check("swap_front1", bus.front_bank_out, 1'b1);
        check("swap_count", n_swaps - swaps_before, 1);
        cycle(1'b0, '0, 1'b1, 8'h11, 1'b0, 1'b1);
        check("gnt_resumes", last_gnt, 1'b1);
        idle(5, 1'b0);

        // Updater read granted just before the rise: swap waits for it to drain.
        cycle(1'b0, '0, 1'b1, 8'h22, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'h22, 1'b0, 1'b1);
        check("deferred_no_ack", bus.swap_ack_out, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 8'h22, 1'b0, 1'b1);
        check("deferred_front0", bus.front_bank_out, 1'b0);
        idle(4, 1'b0);

        // Randomized traffic with periodic vblank.
        u_req = 0; u_addr = '0;
        for (int i = 0; i < 500; i++) begin
            r_en   = ($urandom_range(0, 99) < 40);
            r_addr = LA'($urandom);
            if (!u_req || last_gnt) begin
                u_req  = ($urandom_range(0, 99) < 60);
                u_addr = LA'($urandom);
            end
            s_req = ($urandom_range(0, 99) < 6);
            vb    = ((i % 23) >= 17) || ($urandom_range(0, 99) < 3);
            cycle(r_en, r_addr, u_req, u_addr, s_req, vb);
        end
        idle(4, 1'b0);
        idle(6, 1'b1);
        idle(4, 1'b0);

        // Alternating render / update: every return in order, none lost.
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) cycle(1'b1, LA'($urandom), 1'b0, '0, 1'b0, 1'b0);
            else            cycle(1'b0, '0, 1'b1, LA'(i), 1'b0, 1'b0);
        end
        idle(5, 1'b0);
        check("alt_upd_drained", upd_due_q.size(), 0);
        check("alt_ren_drained", ren_due_q.size(), 0);

        // Two updater reads in flight, then asynchronous reset.
        cycle(1'b0, '0, 1'b1, 8'h40, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 8'h41, 1'b0, 1'b0);
        mid_cycle_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
            check("no_valid_after_reset", bus.upd_valid_out, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
